// File: rtl/stream_lane_alu_if.sv
`default_nettype none
// ============================================================================
// Module   : stream_lane_alu_if
// Brief    : AXI4-Stream bundle (valid/ready/data/keep/last) with master and
//            slave views, used for both sides of the lane ALU.
// Revision : 1.0 - initial release
// ============================================================================
interface stream_lane_alu_if #(
    parameter int DATA_WIDTH = 512
);
    logic                    tvalid;
    logic                    tready;
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tkeep;
    logic                    tlast;

    modport master (output tvalid, tdata, tkeep, tlast, input  tready);
    modport slave  (input  tvalid, tdata, tkeep, tlast, output tready);
endinterface
`default_nettype wire

// File: rtl/stream_lane_alu.sv
`default_nettype none
// ============================================================================
// Module   : stream_lane_alu
// Brief    : Two-stage AXI4-Stream lane ALU. Each beat is split into lanes and
//            a per-packet wrap/saturating add/sub against a constant is
//            applied to every kept lane. Results are buffered in a
//            first-word-fall-through FIFO whose fill drives a registered
//            input ready.
// Revision : 1.0 - initial release
// ============================================================================
module stream_lane_alu #(
    parameter int C_AXIS_TDATA_WIDTH = 512,
    parameter int C_LANE_WIDTH       = 32,
    parameter int C_FIFO_DEPTH       = 32,
    parameter int C_READY_SLACK      = 6
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic [1:0]              ctrl_op,
    input  logic [C_LANE_WIDTH-1:0] ctrl_constant,
    input  logic                    stat_clear,
    stream_lane_alu_if.slave        s_axis,
    stream_lane_alu_if.master       m_axis,
    output logic [31:0]             stat_beats,
    output logic [31:0]             stat_pkts,
    output logic                    stat_sat
);

    localparam int DW         = C_AXIS_TDATA_WIDTH;
    localparam int KW         = DW / 8;
    localparam int LW         = C_LANE_WIDTH;
    localparam int NUM_LANES  = DW / LW;
    localparam int LANE_BYTES = LW / 8;
    localparam int PTR_W      = $clog2(C_FIFO_DEPTH);
    localparam int CNT_W      = PTR_W + 1;
    localparam int OCC_W      = CNT_W + 1;
    localparam int ENTRY_W    = 1 + KW + DW;

    localparam logic [1:0] OP_WRAP_ADD = 2'b00;
    localparam logic [1:0] OP_WRAP_SUB = 2'b01;
    localparam logic [1:0] OP_SAT_ADD  = 2'b10;
    localparam logic [1:0] OP_SAT_SUB  = 2'b11;

    localparam logic [OCC_W-1:0] READY_LIMIT = OCC_W'(C_FIFO_DEPTH - C_READY_SLACK);

    // packet mode state
    logic          first_q,     first_d;
    logic [1:0]    pkt_op_q,    pkt_op_d;
    logic [LW-1:0] pkt_const_q, pkt_const_d;

    // stage 1: registered input beat plus the operation it will use
    logic          s1_valid_q, s1_valid_d;
    logic [DW-1:0] s1_data_q,  s1_data_d;
    logic [KW-1:0] s1_keep_q,  s1_keep_d;
    logic          s1_last_q,  s1_last_d;
    logic [1:0]    s1_op_q,    s1_op_d;
    logic [LW-1:0] s1_const_q, s1_const_d;

    // stage 2: computed beat waiting to be written into the FIFO
    logic          s2_valid_q, s2_valid_d;
    logic [DW-1:0] s2_data_q,  s2_data_d;
    logic [KW-1:0] s2_keep_q,  s2_keep_d;
    logic          s2_last_q,  s2_last_d;
    logic          s2_sat_q,   s2_sat_d;

    // output FIFO
    logic [ENTRY_W-1:0] mem_q [C_FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q,  count_d;

    logic          tready_q,     tready_d;
    logic [31:0]   stat_beats_q, stat_beats_d;
    logic [31:0]   stat_pkts_q,  stat_pkts_d;
    logic          stat_sat_q,   stat_sat_d;

    logic                 w_accept;
    logic                 w_fifo_wr;
    logic                 w_fifo_rd;
    logic [OCC_W-1:0]     w_occupancy;
    logic [DW-1:0]        w_alu_data;
    logic [NUM_LANES-1:0] w_lane_sat;

    assign w_accept  = s_axis.tvalid & tready_q;
    assign w_fifo_wr = s2_valid_q;
    assign w_fifo_rd = (count_q != '0) & m_axis.tready;

    // Everything that will land in the FIFO: buffered beats plus both stages.
    assign w_occupancy = OCC_W'(count_q) + OCC_W'(s1_valid_q) + OCC_W'(s2_valid_q);

    // Per-lane arithmetic on the stage-1 beat.
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
        logic [LW-1:0] w_a;
        logic [LW:0]   w_sum;
        logic [LW:0]   w_diff;
        logic          w_en;
        logic [LW-1:0] w_res;
        logic          w_clamp;

        assign w_a    = s1_data_q[gi*LW +: LW];
        assign w_sum  = {1'b0, w_a} + {1'b0, s1_const_q};
        assign w_diff = {1'b0, w_a} - {1'b0, s1_const_q};
        assign w_en   = |s1_keep_q[gi*LANE_BYTES +: LANE_BYTES];

        // Select the lane result; disabled lanes pass through and never clamp.
        always_comb begin
            w_res   = w_a;
            w_clamp = 1'b0;
            if (w_en) begin
                case (s1_op_q)
                    OP_WRAP_ADD: w_res = w_sum[LW-1:0];
                    OP_WRAP_SUB: w_res = w_diff[LW-1:0];
                    OP_SAT_ADD: begin
                        w_res   = w_sum[LW] ? {LW{1'b1}} : w_sum[LW-1:0];
                        w_clamp = w_sum[LW];
                    end
                    OP_SAT_SUB: begin
                        w_res   = w_diff[LW] ? {LW{1'b0}} : w_diff[LW-1:0];
                        w_clamp = w_diff[LW];
                    end
                    default: w_res = w_a;
                endcase
            end
        end

        assign w_alu_data[gi*LW +: LW] = w_res;
        assign w_lane_sat[gi]          = w_clamp;
    end

    // Next-state for packet mode, pipeline, FIFO bookkeeping, ready and stats.
    always_comb begin
        first_d     = first_q;
        pkt_op_d    = pkt_op_q;
        pkt_const_d = pkt_const_q;
        if (w_accept) begin
            first_d = s_axis.tlast;
            if (first_q) begin
                pkt_op_d    = ctrl_op;
                pkt_const_d = ctrl_constant;
            end
        end

        s1_valid_d = w_accept;
        s1_data_d  = s1_data_q;
        s1_keep_d  = s1_keep_q;
        s1_last_d  = s1_last_q;
        s1_op_d    = s1_op_q;
        s1_const_d = s1_const_q;
        if (w_accept) begin
            s1_data_d  = s_axis.tdata;
            s1_keep_d  = s_axis.tkeep;
            s1_last_d  = s_axis.tlast;
            // The first beat uses the live controls; later beats the latched ones.
            s1_op_d    = first_q ? ctrl_op       : pkt_op_q;
            s1_const_d = first_q ? ctrl_constant : pkt_const_q;
        end

        s2_valid_d = s1_valid_q;
        s2_data_d  = s2_data_q;
        s2_keep_d  = s2_keep_q;
        s2_last_d  = s2_last_q;
        s2_sat_d   = s2_sat_q;
        if (s1_valid_q) begin
            s2_data_d = w_alu_data;
            s2_keep_d = s1_keep_q;
            s2_last_d = s1_last_q;
            s2_sat_d  = |w_lane_sat;
        end

        wr_ptr_d = wr_ptr_q + PTR_W'(w_fifo_wr);
        rd_ptr_d = rd_ptr_q + PTR_W'(w_fifo_rd);
        count_d  = count_q + CNT_W'(w_fifo_wr) - CNT_W'(w_fifo_rd);

        // Slack covers the beats that can still be accepted before ready falls.
        tready_d = (w_occupancy <= READY_LIMIT);

        stat_beats_d = stat_clear ? 32'd0 : stat_beats_q + 32'(w_accept);
        stat_pkts_d  = stat_clear ? 32'd0 : stat_pkts_q + 32'(w_accept & s_axis.tlast);
        stat_sat_d   = stat_clear ? 1'b0  : (stat_sat_q | (s2_valid_q & s2_sat_q));
    end

    // Control state with synchronous active-low reset.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            first_q      <= 1'b1;
            pkt_op_q     <= 2'b00;
            pkt_const_q  <= '0;
            s1_valid_q   <= 1'b0;
            s2_valid_q   <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            tready_q     <= 1'b0;
            stat_beats_q <= 32'd0;
            stat_pkts_q  <= 32'd0;
            stat_sat_q   <= 1'b0;
        end else begin
            first_q      <= first_d;
            pkt_op_q     <= pkt_op_d;
            pkt_const_q  <= pkt_const_d;
            s1_valid_q   <= s1_valid_d;
            s2_valid_q   <= s2_valid_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            tready_q     <= tready_d;
            stat_beats_q <= stat_beats_d;
            stat_pkts_q  <= stat_pkts_d;
            stat_sat_q   <= stat_sat_d;
        end
    end

    // Pipeline payload registers; qualified by the valids so no reset needed.
    always_ff @(posedge aclk) begin
        s1_data_q  <= s1_data_d;
        s1_keep_q  <= s1_keep_d;
        s1_last_q  <= s1_last_d;
        s1_op_q    <= s1_op_d;
        s1_const_q <= s1_const_d;
        s2_data_q  <= s2_data_d;
        s2_keep_q  <= s2_keep_d;
        s2_last_q  <= s2_last_d;
        s2_sat_q   <= s2_sat_d;
    end

    // FIFO storage write port.
    always_ff @(posedge aclk) begin
        if (w_fifo_wr) begin
            mem_q[wr_ptr_q] <= {s2_last_q, s2_keep_q, s2_data_q};
        end
    end

    assign s_axis.tready = tready_q;
    assign m_axis.tvalid = (count_q != '0);
    assign {m_axis.tlast, m_axis.tkeep, m_axis.tdata} = mem_q[rd_ptr_q];

    assign stat_beats = stat_beats_q;
    assign stat_pkts  = stat_pkts_q;
    assign stat_sat   = stat_sat_q;

endmodule
`default_nettype wire

// File: tb/tb_stream_lane_alu.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_lane_alu
// Brief    : Self-checking bench for stream_lane_alu: directed scenarios and
//            randomized traffic scored against a lane-arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stream_lane_alu;

    localparam int DW    = 512;
    localparam int LW    = 32;
    localparam int DEPTH = 32;
    localparam int SLACK = 6;
    localparam int KW    = DW / 8;
    localparam int NL    = DW / LW;
    localparam int LB    = LW / 8;

    typedef struct {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic          l;
    } beat_t;

    logic          clk = 1'b0;
    logic          aresetn = 1'b0;
    logic [1:0]    ctrl_op = 2'b00;
    logic [LW-1:0] ctrl_constant = '0;
    logic          stat_clear = 1'b0;
    logic [31:0]   stat_beats;
    logic [31:0]   stat_pkts;
    logic          stat_sat;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    stream_lane_alu_if #(.DATA_WIDTH(DW)) s_if ();
    stream_lane_alu_if #(.DATA_WIDTH(DW)) m_if ();

    stream_lane_alu #(
        .C_AXIS_TDATA_WIDTH(DW),
        .C_LANE_WIDTH      (LW),
        .C_FIFO_DEPTH      (DEPTH),
        .C_READY_SLACK     (SLACK)
    ) dut (
        .aclk         (clk),
        .aresetn      (aresetn),
        .ctrl_op      (ctrl_op),
        .ctrl_constant(ctrl_constant),
        .stat_clear   (stat_clear),
        .s_axis       (s_if),
        .m_axis       (m_if),
        .stat_beats   (stat_beats),
        .stat_pkts    (stat_pkts),
        .stat_sat     (stat_sat)
    );

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic void apply_op(input logic [DW-1:0] d, input logic [KW-1:0] k,
                                     input logic [1:0] op, input logic [LW-1:0] c,
                                     output logic [DW-1:0] o, output bit sat);
        longint unsigned a, b, r, modv;
        modv = 64'd1 << LW;
        o    = d;
        sat  = 1'b0;
        for (int i = 0; i < NL; i++) begin
            if (k[i*LB +: LB] == '0) continue;
            a = 64'(d[i*LW +: LW]);
            b = 64'(c);
            case (op)
                2'd0: r = (a + b) % modv;
                2'd1: r = (a + modv - b) % modv;
                2'd2: begin
                    r = a + b;
                    if (r > modv - 1) begin r = modv - 1; sat = 1'b1; end
                end
                default: begin
                    if (a < b) begin r = 0; sat = 1'b1; end
                    else r = a - b;
                end
            endcase
            o[i*LW +: LW] = r[LW-1:0];
        end
    endfunction

    beat_t         exp_q[$];
    beat_t         last_pop;
    bit            m_first = 1'b1;
    logic [1:0]    m_op = 2'b00;
    logic [LW-1:0] m_const = '0;
    int            occ = 0;
    bit            wr_pipe0 = 0, wr_pipe1 = 0, sat_pipe0 = 0, sat_pipe1 = 0;
    logic [31:0]   m_beats = 0, m_pkts = 0;
    bit            m_sat = 0;
    bit            hold_prev = 0;
    beat_t         held;

    // Monitor: everything sampled here describes the upcoming rising edge.
    always @(negedge clk) begin
        if (!aresetn) begin
            exp_q.delete();
            m_first = 1'b1;
            occ = 0;
            wr_pipe0 = 0; wr_pipe1 = 0; sat_pipe0 = 0; sat_pipe1 = 0;
            m_beats = 0; m_pkts = 0; m_sat = 0;
            hold_prev = 0;
        end else begin
            bit    acc, rd, wr, wsat, bsat;
            beat_t e;
            check("m_tvalid_vs_fill", m_if.tvalid, occ != 0);
            if (hold_prev) begin
                check("hold_valid", m_if.tvalid, 1'b1);
                check("hold_data", m_if.tdata, held.d);
                check("hold_keep_last", {m_if.tlast, m_if.tkeep}, {held.l, held.k});
            end
            rd = m_if.tvalid & m_if.tready;
            if (rd) begin
                n_checks++;
                assert (exp_q.size() != 0) else begin
                    n_errors++;
                    $error("FAIL out_spurious observed=beat expected=none");
                end
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("out_data", m_if.tdata, e.d);
                    check("out_keep", m_if.tkeep, e.k);
                    check("out_last", m_if.tlast, e.l);
                    last_pop.d = m_if.tdata;
                    last_pop.k = m_if.tkeep;
                    last_pop.l = m_if.tlast;
                end
            end
            hold_prev = m_if.tvalid & !m_if.tready;
            held.d = m_if.tdata; held.k = m_if.tkeep; held.l = m_if.tlast;

            wr = wr_pipe1; wsat = sat_pipe1;
            wr_pipe1 = wr_pipe0; sat_pipe1 = sat_pipe0;
            acc = s_if.tvalid & s_if.tready;
            bsat = 1'b0;
            if (acc) begin
                if (m_first) begin m_op = ctrl_op; m_const = ctrl_constant; end
                apply_op(s_if.tdata, s_if.tkeep, m_op, m_const, e.d, bsat);
                e.k = s_if.tkeep;
                e.l = s_if.tlast;
                exp_q.push_back(e);
                m_first = s_if.tlast;
            end
            wr_pipe0 = acc; sat_pipe0 = acc & bsat;

            occ = occ + int'(wr) - int'(rd);
            n_checks++;
            assert (occ <= DEPTH) else begin
                n_errors++;
                $error("FAIL fifo_overflow observed=%0d expected<=%0d", occ, DEPTH);
            end

            if (stat_clear) begin m_beats = 0; m_pkts = 0; m_sat = 0; end
            else begin
                m_beats = m_beats + 32'(acc);
                m_pkts  = m_pkts + 32'(acc & s_if.tlast);
                m_sat   = m_sat | wsat;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [DW-1:0] fill(input logic [LW-1:0] v);
        logic [DW-1:0] d;
        for (int i = 0; i < NL; i++) d[i*LW +: LW] = v;
        return d;
    endfunction

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        for (int i = 0; i < NL; i++) d[i*LW +: LW] = $urandom;
        return d;
    endfunction

    function automatic logic [KW-1:0] rand_keep();
        logic [KW-1:0] k;
        if ($urandom_range(1) == 0) return '1;
        k = {$urandom, $urandom};
        for (int i = 0; i < NL; i++)
            if ($urandom_range(3) == 0) k[i*LB +: LB] = '0;
        return k;
    endfunction

    function automatic logic [LW-1:0] rand_const();
        case ($urandom_range(3))
            0: return $urandom;
            1: return LW'($urandom_range(15));
            2: return 32'hFFFF_FFFF - LW'($urandom_range(15));
            default: return 32'h8000_0000;
        endcase
    endfunction

    task automatic send(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l);
        bit acc = 1'b0;
        s_if.tvalid = 1'b1; s_if.tdata = d; s_if.tkeep = k; s_if.tlast = l;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk);
            acc = s_if.tready;
            @(posedge clk); #1;
        end
        s_if.tvalid = 1'b0;
        check("send_accepted", acc, 1'b1);
    endtask

    task automatic drain(input int max_cycles);
        int i = 0;
        while ((exp_q.size() != 0 || m_if.tvalid) && i < max_cycles) begin
            @(posedge clk); #1;
            i++;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    task automatic run_random(input int nbeats, input int ready_pct, input int max_cycles,
                              output int sent);
        bit hold = 1'b0;
        bit acc;
        sent = 0;
        for (int cyc = 0; cyc < max_cycles && sent < nbeats; cyc++) begin
            if (!hold) begin
                s_if.tvalid   = ($urandom_range(99) < 85);
                s_if.tdata    = rand_data();
                s_if.tkeep    = rand_keep();
                s_if.tlast    = ($urandom_range(3) == 0);
                ctrl_op       = 2'($urandom_range(3));
                ctrl_constant = rand_const();
            end
            m_if.tready = ($urandom_range(99) < ready_pct);
            @(negedge clk);
            acc  = s_if.tvalid & s_if.tready;
            hold = s_if.tvalid & !acc;
            @(posedge clk); #1;
            if (acc) sent++;
        end
        s_if.tvalid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        logic [DW-1:0] d, e;
        int sent;
        s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tkeep = '0; s_if.tlast = 1'b0;
        m_if.tready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("rst_s_tready", s_if.tready, 1'b0);
        check("rst_m_tvalid", m_if.tvalid, 1'b0);
        check("rst_beats", stat_beats, 0);
        check("rst_pkts", stat_pkts, 0);
        check("rst_sat", stat_sat, 1'b0);
        aresetn = 1'b1;
        @(posedge clk); #1;
        check("tready_after_reset", s_if.tready, 1'b1);

        // wrap add, latency
        ctrl_op = 2'b00; ctrl_constant = 32'd5;
        send(fill(32'h10), '1, 1'b0);
        check("lat_n", m_if.tvalid, 1'b0);
        @(posedge clk); #1;
        check("lat_n1", m_if.tvalid, 1'b0);
        @(posedge clk); #1;
        check("lat_n2", m_if.tvalid, 1'b1);
        check("lat_data", m_if.tdata, fill(32'h15));
        send(fill(32'h10), '1, 1'b0);
        send(fill(32'h10), '1, 1'b0);
        send(fill(32'h10), '1, 1'b1);
        drain(100);
        check("t1_last_data", last_pop.d, fill(32'h15));
        check("t1_beats", stat_beats, 4);
        check("t1_pkts", stat_pkts, 1);
        check("t1_sat", stat_sat, 1'b0);

        // saturating add
        ctrl_op = 2'b10; ctrl_constant = 32'hFFFF_FFF0;
        send(fill(32'h20), '1, 1'b1);
        drain(100);
        check("satadd_data", last_pop.d, fill(32'hFFFF_FFFF));
        check("satadd_flag", stat_sat, 1'b1);

        stat_clear = 1'b1;
        @(posedge clk); #1;
        stat_clear = 1'b0;
        check("clear_sat", stat_sat, 1'b0);
        check("clear_beats", stat_beats, 0);
        check("clear_pkts", stat_pkts, 0);

        // saturating sub
        ctrl_op = 2'b11; ctrl_constant = 32'h30;
        send(fill(32'h20), '1, 1'b1);
        drain(100);
        check("satsub_data", last_pop.d, fill(32'h0));
        check("satsub_flag", stat_sat, 1'b1);

        // clear coinciding with accept
        ctrl_op = 2'b00; ctrl_constant = 32'd0;
        stat_clear = 1'b1;
        send(fill(32'h1), '1, 1'b1);
        stat_clear = 1'b0;
        check("clear_wins_beats", stat_beats, 0);
        check("clear_wins_pkts", stat_pkts, 0);
        check("clear_wins_sat", stat_sat, 1'b0);
        drain(100);

        // partial tkeep
        ctrl_op = 2'b00; ctrl_constant = 32'd1;
        d = rand_data();
        e = d;
        e[LW-1:0] = d[LW-1:0] + 32'd1;
        send(d, 64'h000F, 1'b1);
        drain(100);
        check("keep_data", last_pop.d, e);
        check("keep_out", last_pop.k, 64'h000F);

        // op change mid-packet is ignored; next packet picks it up
        ctrl_op = 2'b00; ctrl_constant = 32'd7;
        send(fill(32'h100), '1, 1'b0);
        ctrl_op = 2'b01;
        send(fill(32'h200), '1, 1'b0);
        send(fill(32'h300), '1, 1'b1);
        check("midpkt_prev_pop", exp_q.size() <= 3, 1'b1);
        drain(100);
        check("midpkt_last_add", last_pop.d, fill(32'h307));
        send(fill(32'h100), '1, 1'b1);
        drain(100);
        check("next_pkt_sub", last_pop.d, fill(32'hF9));

        // backpressure: output stalled, continuous input
        run_random(60, 0, 60, sent);
        check("bp_s_tready_low", s_if.tready, 1'b0);
        check("bp_bounded", (sent >= DEPTH - SLACK) && (sent <= DEPTH), 1'b1);
        m_if.tready = 1'b1;
        drain(200);

        // randomized traffic with random output ready
        run_random(1000, 55, 20000, sent);
        check("rand_sent", sent, 1000);
        m_if.tready = 1'b1;
        drain(400);
        check("rand_beats", stat_beats, m_beats);
        check("rand_pkts", stat_pkts, m_pkts);
        check("rand_sat", stat_sat, m_sat);

        // reset mid-packet with the FIFO half full
        m_if.tready = 1'b0;
        ctrl_op = 2'b00; ctrl_constant = 32'd1;
        for (int i = 0; i < 16; i++) send(rand_data(), '1, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("pre_rst_valid", m_if.tvalid, 1'b1);
        aresetn = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_m_tvalid", m_if.tvalid, 1'b0);
        check("mid_rst_beats", stat_beats, 0);
        check("mid_rst_pkts", stat_pkts, 0);
        check("mid_rst_sat", stat_sat, 1'b0);
        aresetn = 1'b1;
        m_if.tready = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_tready", s_if.tready, 1'b1);
        ctrl_op = 2'b01; ctrl_constant = 32'd3;
        send(fill(32'h10), '1, 1'b1);
        drain(100);
        check("post_rst_new_pkt", last_pop.d, fill(32'h0D));
        check("post_rst_beats", stat_beats, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
